// File: rtl/irrigacao_leitor.sv
// irrigacao_leitor: recovers the 2-bit irrigation code from the 7 segment lines.
// Optional macro IRRIG_CHGCNT_EN adds the trocas/falhas event counters.
module irrigacao_leitor #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    output logic [1:0] Saida,
    output logic       valido,
    output logic       erro,
    output logic       upd
`ifdef IRRIG_CHGCNT_EN
    ,
    output logic [7:0] trocas,
    output logic [3:0] falhas
`endif
);

    localparam logic [3:0] SC = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT,
        S_LOCK,
        S_FAULT
    } state_t;

    state_t     state;
    logic [6:0] seg_q;
    logic [6:0] cand;
    logic [3:0] cnt;
    logic       acc_done;
    logic       accept;
    logic       legal;
    logic [1:0] code;

    // One-shot accept: fires once when the candidate first reaches saturation
    assign accept = (cnt == SC) && !acc_done;

    // Map the stable candidate to a code; anything else is illegal
    always_comb begin
        legal = 1'b1;
        code  = 2'd0;
        case (cand)
            7'b0000000: code = 2'd0;
            7'b1111110: code = 2'd1;
            7'b0110000: code = 2'd2;
            7'b1101101: code = 2'd3;
            default:    legal = 1'b0;
        endcase
    end

    // Register the pins, then track how long the sampled pattern has held
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q    <= '0;
            cand     <= '0;
            cnt      <= '0;
            acc_done <= 1'b0;
        end else begin
            seg_q <= {A, B, C, D, E, F, G};
            if (seg_q != cand) begin
                cand     <= seg_q;
                cnt      <= 4'd1;
                acc_done <= 1'b0;
            end else begin
                if (cnt < SC)
                    cnt <= cnt + 4'd1;
                if (accept)
                    acc_done <= 1'b1;
            end
        end
    end

    // State machine with registered outputs, advancing only on accept events
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_WAIT;
            Saida  <= 2'd0;
            valido <= 1'b0;
            erro   <= 1'b0;
            upd    <= 1'b0;
`ifdef IRRIG_CHGCNT_EN
            trocas <= 8'd0;
            falhas <= 4'd0;
`endif
        end else begin
            upd <= 1'b0;
            if (accept) begin
                if (legal) begin
                    // FAULT->LOCK always announces, even with the same code
                    if (state != S_LOCK || code != Saida) begin
                        Saida <= code;
                        upd   <= 1'b1;
`ifdef IRRIG_CHGCNT_EN
                        trocas <= trocas + 8'd1;
`endif
                    end
                    state  <= S_LOCK;
                    valido <= 1'b1;
                    erro   <= 1'b0;
                end else begin
`ifdef IRRIG_CHGCNT_EN
                    if (state != S_FAULT && falhas != 4'd15)
                        falhas <= falhas + 4'd1;
`endif
                    state  <= S_FAULT;
                    valido <= 1'b0;
                    erro   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_irrigacao_leitor.sv
// tb_irrigacao_leitor: directed checks of the segment-code reader.
// Exercises reset, latency, glitch filtering, fault entry/exit and counters.
module tb_irrigacao_leitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       A, B, C, D, E, F, G;
    logic [1:0] Saida;
    logic       valido, erro, upd;
`ifdef IRRIG_CHGCNT_EN
    logic [7:0] trocas;
    logic [3:0] falhas;
`endif

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] P0  = 7'b0000000;
    localparam logic [6:0] P1  = 7'b1111110;
    localparam logic [6:0] P2  = 7'b0110000;
    localparam logic [6:0] P3  = 7'b1101101;
    localparam logic [6:0] BAD = 7'b1010101;

    irrigacao_leitor #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .Saida(Saida), .valido(valido), .erro(erro), .upd(upd)
`ifdef IRRIG_CHGCNT_EN
        , .trocas(trocas), .falhas(falhas)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setp(input logic [6:0] p);
        {A, B, C, D, E, F, G} = p;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input int s, input int v,
                           input int e, input int u);
        chk({tag, ".Saida"}, int'(Saida), s);
        chk({tag, ".valido"}, int'(valido), v);
        chk({tag, ".erro"}, int'(erro), e);
        chk({tag, ".upd"}, int'(upd), u);
    endtask

    initial begin
        reset = 1'b1;
        setp(P0);
        tick(2);
        chk_out("reset", 0, 0, 0, 0);

        // 0000000 held from reset: accepted after 5 edges
        reset = 1'b0;
        tick(4);
        chk_out("zero_e4", 0, 0, 0, 0);
        tick(1);
        chk_out("zero_e5", 0, 1, 0, 1);
        tick(1);
        chk_out("zero_e6", 0, 1, 0, 0);

        // code 1: outputs change after edge n+5
        setp(P1);
        tick(5);
        chk_out("one_e4", 0, 1, 0, 0);
        tick(1);
        chk_out("one_e5", 1, 1, 0, 1);
        tick(1);
        chk_out("one_e6", 1, 1, 0, 0);

        // 2-cycle glitch to code 2 is ignored
        setp(P2);
        tick(2);
        setp(P1);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch.upd", int'(upd), 0);
        end
        chk_out("glitch_end", 1, 1, 0, 0);

        // illegal pattern -> FAULT, Saida holds
        setp(BAD);
        tick(6);
        chk_out("fault1", 1, 0, 1, 0);
        setp(P3);
        tick(6);
        chk_out("lock3", 3, 1, 0, 1);
        tick(1);
        chk_out("lock3_hold", 3, 1, 0, 0);

        // FAULT then same code: upd fires although Saida stays 3
        setp(BAD);
        tick(6);
        chk_out("fault2", 3, 0, 1, 0);
        setp(P3);
        tick(6);
        chk_out("relock3", 3, 1, 0, 1);

        // reset during a settle cancels the pending accept
        setp(P1);
        tick(3);
        reset = 1'b1;
        tick(1);
        chk_out("midreset", 0, 0, 0, 0);
        reset = 1'b0;
        tick(1);
        chk_out("post_rst_e4", 0, 0, 0, 0);
        tick(1);
        chk_out("post_rst_e5", 0, 0, 0, 0);
        tick(3);
        chk_out("post_rst_e8", 0, 0, 0, 0);
        tick(1);
        chk_out("post_rst_e9", 1, 1, 0, 1);

`ifdef IRRIG_CHGCNT_EN
        reset = 1'b1;
        setp(P0);
        tick(1);
        reset = 1'b0;
        chk("trocas_rst", int'(trocas), 0);
        chk("falhas_rst", int'(falhas), 0);
        for (int i = 0; i < 300; i++) begin
            setp(P1); tick(6);
            setp(P2); tick(6);
            setp(P3); tick(6);
            setp(P0); tick(6);
        end
        chk("trocas_wrap", int'(trocas), 176);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            setp(BAD); tick(6);
            setp(P1); tick(6);
        end
        chk("falhas_sat", int'(falhas), 15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
